// File: rtl/rng_pkg.sv
// Shared definitions for the ranged random-number unit: FSM encoding,
// default Galois feedback masks and the range-mask helper.
package rng_pkg;

   typedef enum logic {StIdle, StDraw} rng_state_t;

   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;
   localparam logic [31:0] TAPS_W32 = 32'h80200003;

   // Smallest all-ones value covering v (copies the top set bit into every lower position).
   function automatic logic [31:0] smear_mask(input logic [31:0] v);
      logic [31:0] m;
      m = v;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with synchronous seed load; a zero seed is replaced by all-ones
// so the register can never lock up in the all-zero state.
module lfsr_galois #(
   parameter int unsigned        LFSR_W = 16,
   parameter logic [LFSR_W-1:0]  TAPS   = 16'hB400
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= '1;
      end else if (load) begin
         state <= (seed == '0) ? '1 : seed;
      end else if (step) begin
         state <= (state >> 1) ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/ranged_rng_unit.sv
// Handshaked random-number unit returning unbiased values in [min_val, max_val]
// by masked rejection sampling with a bounded retry count and subtract fallback.
module ranged_rng_unit
   import rng_pkg::*;
#(
   parameter int unsigned        WIDTH     = 8,
   parameter int unsigned        LFSR_W    = 16,
   parameter logic [LFSR_W-1:0]  TAPS      = TAPS_W16,
   parameter int unsigned        MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              free_run,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              req,
   input  logic [WIDTH-1:0]  min_val,
   input  logic [WIDTH-1:0]  max_val,
   output logic              ready,
   output logic              valid,
   output logic [WIDTH-1:0]  random_num,
   output logic              fallback
);

   localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   rng_state_t         state;
   logic [LFSR_W-1:0]  lfsr;
   logic [TRY_W-1:0]   tries;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH:0]     range_len;
   logic [WIDTH-1:0]   mask;

   logic               accept;
   logic [WIDTH-1:0]   lo_n;
   logic [WIDTH-1:0]   hi_n;
   logic [WIDTH-1:0]   cand;
   logic               hit;
   logic               last_try;
   logic [WIDTH-1:0]   result;

   lfsr_galois #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  ((state == StDraw) || ((state == StIdle) && free_run)),
      .load  (seed_load),
      .seed  (seed),
      .state (lfsr)
   );

   if (LFSR_W > WIDTH) begin : g_unused_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr[LFSR_W-1:WIDTH];
   end

   // Ready stays low through the valid cycle so results are at least 3 cycles apart.
   assign ready  = (state == StIdle) && !valid;
   assign accept = req && ready && !seed_load;

   always_comb begin
      if (max_val >= min_val) begin
         lo_n = min_val;
         hi_n = max_val;
      end else begin
         lo_n = '0;
         hi_n = '1;
      end
   end

   assign cand     = lfsr[WIDTH-1:0] & mask;
   assign hit      = {1'b0, cand} < range_len;
   assign last_try = (tries == TRY_W'(MAX_TRIES - 1));
   assign result   = hit ? cand : WIDTH'({1'b0, cand} - range_len);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         tries      <= '0;
         lo         <= '0;
         range_len  <= '0;
         mask       <= '0;
         valid      <= 1'b0;
         fallback   <= 1'b0;
         random_num <= '0;
      end else begin
         valid    <= 1'b0;
         fallback <= 1'b0;
         if (seed_load) begin
            state <= StIdle;
            tries <= '0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (accept) begin
                     lo        <= lo_n;
                     range_len <= {1'b0, hi_n} - {1'b0, lo_n} + (WIDTH+1)'(1);
                     mask      <= WIDTH'(smear_mask(32'(hi_n - lo_n)));
                     tries     <= '0;
                     state     <= StDraw;
                  end
               end
               StDraw: begin
                  if (hit || last_try) begin
                     random_num <= lo + result;
                     valid      <= 1'b1;
                     fallback   <= !hit;
                     tries      <= '0;
                     state      <= StIdle;
                  end else begin
                     tries <= tries + 1'b1;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ranged_rng_unit.sv
// Directed bench for ranged_rng_unit: reset, degenerate/full/inverted ranges,
// fallback path, seed-load abort, random range sweep and mid-draw reset.
module tb_ranged_rng_unit;

   logic        clk;
   logic        rst;
   logic        free_run;
   logic        seed_load;
   logic [15:0] seed;
   logic        req;
   logic [7:0]  min_val;
   logic [7:0]  max_val;
   logic        ready, valid, fallback;
   logic [7:0]  random_num;
   logic        ready1, valid1, fallback1;
   logic [7:0]  random_num1;

   int checks = 0;
   int errors = 0;
   int gap_viol = 0;
   int gap_cnt = 0;
   bit gap_seen = 0;

   ranged_rng_unit #(
      .WIDTH     (8),
      .LFSR_W    (16),
      .TAPS      (16'hB400),
      .MAX_TRIES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .free_run   (free_run),
      .seed_load  (seed_load),
      .seed       (seed),
      .req        (req),
      .min_val    (min_val),
      .max_val    (max_val),
      .ready      (ready),
      .valid      (valid),
      .random_num (random_num),
      .fallback   (fallback)
   );

   ranged_rng_unit #(
      .WIDTH     (8),
      .LFSR_W    (16),
      .TAPS      (16'hB400),
      .MAX_TRIES (1)
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
      .free_run   (free_run),
      .seed_load  (seed_load),
      .seed       (seed),
      .req        (req),
      .min_val    (min_val),
      .max_val    (max_val),
      .ready      (ready1),
      .valid      (valid1),
      .random_num (random_num1),
      .fallback   (fallback1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (rst) begin
         gap_seen = 0;
         gap_cnt  = 0;
      end else if (valid) begin
         if (gap_seen && (gap_cnt + 1 < 3)) gap_viol++;
         gap_seen = 1;
         gap_cnt  = 0;
      end else begin
         gap_cnt++;
      end
   end

   function automatic logic [15:0] step16(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where valid is seen.
   task automatic do_req(input logic [7:0] lo, input logic [7:0] hi,
                         output logic [7:0] num, output int lat, output logic fb);
      int n;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_wait", {31'd0, ready}, 32'd1);
      min_val = lo;
      max_val = hi;
      req     = 1'b1;
      @(negedge clk);
      req = 1'b0;
      lat = 1;
      while (!valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!valid) chk("valid_wait", {31'd0, valid}, 32'd1);
      num = random_num;
      fb  = fallback;
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed      = s;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
   endtask

   initial begin
      logic [15:0] model;
      logic [7:0]  num, elo, ehi;
      logic        fb;
      int          lat;

      rst = 1'b1; free_run = 1'b0; seed_load = 1'b0; seed = '0;
      req = 1'b0; min_val = '0; max_val = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_fallback", {31'd0, fallback}, 32'd0);
      chk("rst_num", {24'd0, random_num}, 32'd0);
      chk("rst_lfsr", {16'd0, dut.u_lfsr.state}, 32'hFFFF);
      rst = 1'b0;
      @(negedge clk);

      // Single-value range: mask 0, so the first candidate always resolves.
      do_req(8'd10, 8'd10, num, lat, fb);
      chk("single_num", {24'd0, num}, 32'd10);
      chk("single_lat", lat, 32'd2);
      chk("single_fb", {31'd0, fb}, 32'd0);
      model = step16(16'hFFFF);

      for (int i = 0; i < 300; i++) begin
         do_req(8'd0, 8'd255, num, lat, fb);
         chk("full_num", {24'd0, num}, {24'd0, model[7:0]});
         chk("full_lat", lat, 32'd2);
         model = step16(model);
      end

      load_seed(16'h00C8);
      do_req(8'd200, 8'd100, num, lat, fb);
      chk("inv_num", {24'd0, num}, 32'd200);
      chk("inv_lat", lat, 32'd2);

      // Fallback on the 1-try instance; the 8-try instance retries once instead.
      load_seed(16'h00C8);
      chk("fb_ready", {31'd0, ready}, 32'd1);
      min_val = 8'd0;
      max_val = 8'd128;
      req     = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("fb_valid_early", {31'd0, valid1}, 32'd0);
      @(negedge clk);
      chk("fb_valid", {31'd0, valid1}, 32'd1);
      chk("fb_num", {24'd0, random_num1}, 32'd71);
      chk("fb_flag", {31'd0, fallback1}, 32'd1);
      chk("retry_pending", {31'd0, valid}, 32'd0);
      @(negedge clk);
      chk("retry_valid", {31'd0, valid}, 32'd1);
      chk("retry_num", {24'd0, random_num}, 32'd100);
      chk("retry_fb", {31'd0, fallback}, 32'd0);
      @(negedge clk);

      // Seed load during the first DRAW cycle aborts the pending retry.
      load_seed(16'h1203);
      min_val = 8'd0;
      max_val = 8'd2;
      req     = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("abort_busy", {31'd0, ready}, 32'd0);
      seed      = 16'hABCD;
      seed_load = 1'b1;
      @(negedge clk);
      chk("abort_valid", {31'd0, valid}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_lfsr", {16'd0, dut.u_lfsr.state}, 32'hABCD);
      seed = 16'h0000;
      @(negedge clk);
      chk("zero_seed", {16'd0, dut.u_lfsr.state}, 32'hFFFF);
      seed    = 16'h0005;
      req     = 1'b1;
      max_val = 8'd255;
      @(negedge clk);
      req       = 1'b0;
      seed_load = 1'b0;
      chk("load_blocks_req", {31'd0, ready}, 32'd1);
      chk("load_value", {16'd0, dut.u_lfsr.state}, 32'h0005);
      @(negedge clk);
      chk("no_draw", {31'd0, valid}, 32'd0);

      for (int i = 0; i < 10000; i++) begin
         free_run = 1'($urandom_range(0, 1));
         elo = 8'($urandom);
         ehi = 8'($urandom);
         do_req(elo, ehi, num, lat, fb);
         if (ehi < elo) begin
            elo = 8'd0;
            ehi = 8'd255;
         end
         chk("rand_in_range", {31'd0, (num >= elo) && (num <= ehi)}, 32'd1);
         chk("rand_lat_max", {31'd0, lat <= 9}, 32'd1);
      end
      free_run = 1'b0;
      chk("valid_gap", gap_viol, 32'd0);

      do_req(8'd77, 8'd77, num, lat, fb);
      chk("pre_rst_num", {24'd0, num}, 32'd77);
      @(negedge clk);
      load_seed(16'h1203);
      min_val = 8'd0;
      max_val = 8'd2;
      req     = 1'b1;
      @(negedge clk);
      req = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ready", {31'd0, ready}, 32'd1);
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_fb", {31'd0, fallback}, 32'd0);
      chk("mid_rst_num", {24'd0, random_num}, 32'd0);
      chk("mid_rst_lfsr", {16'd0, dut.u_lfsr.state}, 32'hFFFF);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
